// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt sequencer: register map, TCON/ICAUSE fields,
// FSM encoding and the fixed-priority helper.
package irq_pkg;

  localparam logic [2:0] REG_TH     = 3'd0;
  localparam logic [2:0] REG_TL     = 3'd1;
  localparam logic [2:0] REG_TCON   = 3'd2;
  localparam logic [2:0] REG_IMASK  = 3'd3;
  localparam logic [2:0] REG_IPEND  = 3'd4;
  localparam logic [2:0] REG_ICAUSE = 3'd5;

  localparam int TCON_EN      = 0;
  localparam int TCON_IE      = 1;
  localparam int ICAUSE_VALID = 31;
  localparam int ICAUSE_ID_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_SVC  = 2'b10
  } state_e;

  // Index of the lowest set bit; bit 0 has the highest priority.
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i[4:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_timer.sv
// Free-running reload timer: TH reload, TL count, TCON control, and a one-cycle
// overflow pulse qualified by the timer interrupt enable.
module irq_timer
  import irq_pkg::*;
#(
  parameter logic [31:0] TH_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        th_we,
  input  logic        tl_we,
  input  logic        tcon_we,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [1:0]  tcon,
  output logic        tim_ovf
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [1:0]  tcon_q, tcon_d;

  // Next-state for reload, count and control; a bus write to TL beats counting.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (th_we) begin
      th_d = wdata;
    end else begin
      th_d = th_q;
    end
    if (tcon_we) begin
      tcon_d = wdata[1:0];
    end else begin
      tcon_d = tcon_q;
    end
    if (tl_we) begin
      tl_d = wdata;
    end else if (tcon_q[TCON_EN]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end else begin
      tl_d = tl_q;
    end
  end

  // Timer register bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= TH_RST;
      tl_q   <= 32'h0000_0000;
      tcon_q <= 2'b00;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th      = th_q;
  assign tl      = tl_q;
  assign tcon    = tcon_q;
  assign tim_ovf = tcon_q[TCON_EN] & tcon_q[TCON_IE] & (tl_q == 32'hFFFF_FFFF);

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt sequencer: pending/mask registers, fixed-priority winner, request FSM
// with ack/eret handshake, and the memory-mapped register decode.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          N_EXT  = 3,
  parameter logic [31:0] TH_RST = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_EXT-1:0] src_irq,
  input  logic             cs,
  input  logic [4:0]       addr,
  input  logic             wr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic             kernel,
  input  logic             irq_ack,
  input  logic             eret,
  output logic             irq
);

  localparam int NS = N_EXT + 1;

  logic [2:0]       reg_idx;
  logic             bus_we;
  logic [31:0]      th, tl;
  logic [1:0]       tcon;
  logic             tim_ovf;

  logic [N_EXT-1:0] src_sync_q, src_prev_q, src_edge;
  logic [NS-1:0]    ipend_q, ipend_d;
  logic [NS-1:0]    imask_q, imask_d;
  logic [NS-1:0]    act;
  logic [4:0]       winner;

  state_e           state_q, state_d;
  logic             irq_q, irq_d;
  logic             icause_valid_q, icause_valid_d;
  logic [4:0]       icause_id_q, icause_id_d;

  logic             unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  assign reg_idx = addr[4:2];
  assign bus_we  = cs & wr;

  irq_timer #(.TH_RST(TH_RST)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .th_we   (bus_we && (reg_idx == REG_TH)),
    .tl_we   (bus_we && (reg_idx == REG_TL)),
    .tcon_we (bus_we && (reg_idx == REG_TCON)),
    .wdata   (wdata),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .tim_ovf (tim_ovf)
  );

  assign src_edge = src_sync_q & ~src_prev_q;
  assign act      = ipend_q & imask_q;
  assign winner   = lowest_set({{(32-NS){1'b0}}, act});

  // Pending and mask update; a set in the same cycle as a W1C keeps the bit.
  always_comb begin
    ipend_d = ipend_q;
    imask_d = imask_q;
    if (bus_we && (reg_idx == REG_IPEND)) begin
      ipend_d = ipend_q & ~wdata[NS-1:0];
    end else begin
      ipend_d = ipend_q;
    end
    ipend_d = ipend_d | {src_edge, tim_ovf};
    if (bus_we && (reg_idx == REG_IMASK)) begin
      imask_d = wdata[NS-1:0];
    end else begin
      imask_d = imask_q;
    end
  end

  // Request FSM and cause latch; irq follows the next state so it is a clean flop.
  always_comb begin
    state_d        = state_q;
    icause_valid_d = icause_valid_q;
    icause_id_d    = icause_id_q;
    case (state_q)
      ST_IDLE: begin
        if ((|act) && !kernel) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_d        = ST_SVC;
          icause_valid_d = 1'b1;
          icause_id_d    = winner;
        end else if (!(|act) || kernel) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_SVC: begin
        if (eret) begin
          state_d        = ST_IDLE;
          icause_valid_d = 1'b0;
        end else begin
          state_d = ST_SVC;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    irq_d = (state_d == ST_REQ);
  end

  // Control state, source synchronisers and interrupt registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      irq_q          <= 1'b0;
      icause_valid_q <= 1'b0;
      icause_id_q    <= 5'd0;
      ipend_q        <= {NS{1'b0}};
      imask_q        <= {NS{1'b0}};
      src_sync_q     <= {N_EXT{1'b0}};
      src_prev_q     <= {N_EXT{1'b0}};
    end else begin
      state_q        <= state_d;
      irq_q          <= irq_d;
      icause_valid_q <= icause_valid_d;
      icause_id_q    <= icause_id_d;
      ipend_q        <= ipend_d;
      imask_q        <= imask_d;
      src_sync_q     <= src_irq;
      src_prev_q     <= src_sync_q;
    end
  end

  assign irq = irq_q;

  // Combinational read mux; unmapped offsets and cs=0 read as zero.
  always_comb begin
    rdata = 32'h0000_0000;
    if (cs) begin
      case (reg_idx)
        REG_TH:     rdata = th;
        REG_TL:     rdata = tl;
        REG_TCON:   rdata = {30'd0, tcon};
        REG_IMASK:  rdata = {{(32-NS){1'b0}}, imask_q};
        REG_IPEND:  rdata = {{(32-NS){1'b0}}, ipend_q};
        REG_ICAUSE: rdata = {icause_valid_q, 26'd0, icause_id_q};
        default:    rdata = 32'h0000_0000;
      endcase
    end else begin
      rdata = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register-map vector table plus hand-written
// sequences for timer, handshake, priority, masking, collision and reset.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  src_irq;
  logic        cs, wr, kernel, irq_ack, eret;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [4:0] A_TH = 5'h00, A_TL = 5'h04, A_TCON = 5'h08,
                         A_IMASK = 5'h0C, A_IPEND = 5'h10, A_ICAUSE = 5'h14;

  irq_ctrl #(.N_EXT(3), .TH_RST(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .src_irq(src_irq), .cs(cs), .addr(addr), .wr(wr),
    .wdata(wdata), .rdata(rdata), .kernel(kernel), .irq_ack(irq_ack), .eret(eret),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_wr;
    logic [4:0]  waddr;
    logic [31:0] wdat;
    logic        rd_cs;
    logic [4:0]  raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    tick();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [4:0] a, input logic [31:0] exp);
    cs = 1'b1; wr = 1'b0; addr = a;
    #1;
    check(name, rdata, exp);
    cs = 1'b0;
  endtask

  task automatic wait_irq(input string name);
    for (int i = 0; i < 8; i++) begin
      if (irq) break;
      tick();
    end
    check(name, {31'd0, irq}, 32'd1);
  endtask

  task automatic handshake(input logic [4:0] id);
    wait_irq("hs_irq");
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    rd_check("hs_icause", A_ICAUSE, {1'b1, 26'd0, id});
    check("hs_irq_low", {31'd0, irq}, 32'd0);
    bus_write(A_IPEND, 32'd1 << id);
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin
    reset = 1'b1; src_irq = 3'b000; cs = 1'b0; wr = 1'b0; addr = 5'd0;
    wdata = 32'd0; kernel = 1'b0; irq_ack = 1'b0; eret = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset_irq", {31'd0, irq}, 32'd0);

    vecs[0]  = '{1'b0, A_TH,     32'h0,          1'b1, A_TH,     32'h0000_0000, "rst_th"};
    vecs[1]  = '{1'b0, A_TH,     32'h0,          1'b1, A_ICAUSE, 32'h0000_0000, "rst_icause"};
    vecs[2]  = '{1'b1, A_TH,     32'h1234_5678,  1'b1, A_TH,     32'h1234_5678, "th_rw"};
    vecs[3]  = '{1'b1, A_IMASK,  32'hFFFF_FFFF,  1'b1, A_IMASK,  32'h0000_000F, "imask_width"};
    vecs[4]  = '{1'b1, A_TCON,   32'hFFFF_FFFC,  1'b1, A_TCON,   32'h0000_0000, "tcon_width"};
    vecs[5]  = '{1'b1, A_TCON,   32'h0000_0002,  1'b1, A_TCON,   32'h0000_0002, "tcon_ie"};
    vecs[6]  = '{1'b1, A_ICAUSE, 32'hFFFF_FFFF,  1'b1, A_ICAUSE, 32'h0000_0000, "icause_ro"};
    vecs[7]  = '{1'b1, 5'h18,    32'hFFFF_FFFF,  1'b1, 5'h18,    32'h0000_0000, "unmapped"};
    vecs[8]  = '{1'b1, A_TL,     32'h0000_00AB,  1'b1, A_TL,     32'h0000_00AB, "tl_rw"};
    vecs[9]  = '{1'b1, A_IPEND,  32'h0000_000F,  1'b1, A_IPEND,  32'h0000_0000, "ipend_w1c"};
    vecs[10] = '{1'b0, A_TH,     32'h0,          1'b0, A_TH,     32'h0000_0000, "cs_low"};
    vecs[11] = '{1'b0, A_TH,     32'h0,          1'b1, 5'h03,    32'h1234_5678, "addr_lsb"};
    vecs[12] = '{1'b1, A_IMASK,  32'h0000_0000,  1'b1, A_IMASK,  32'h0000_0000, "imask_clr"};
    vecs[13] = '{1'b1, A_TCON,   32'h0000_0000,  1'b1, A_TCON,   32'h0000_0000, "tcon_clr"};

    foreach (vecs[i]) begin
      if (vecs[i].do_wr) bus_write(vecs[i].waddr, vecs[i].wdat);
      cs = vecs[i].rd_cs; wr = 1'b0; addr = vecs[i].raddr;
      #1;
      check(vecs[i].name, rdata, vecs[i].exp);
      cs = 1'b0;
    end
    check("table_irq", {31'd0, irq}, 32'd0);

    // Timer reload period and irq latency.
    bus_write(A_TH, 32'hFFFF_FFFC);
    bus_write(A_TL, 32'hFFFF_FFFC);
    bus_write(A_IMASK, 32'h1);
    bus_write(A_TCON, 32'h3);
    for (int k = 1; k <= 4; k++) begin
      tick();
      rd_check($sformatf("tim_pend_c%0d", k), A_IPEND, (k == 4) ? 32'h1 : 32'h0);
    end
    check("tim_irq_pre", {31'd0, irq}, 32'd0);
    tick();
    check("tim_irq", {31'd0, irq}, 32'd1);

    // Handshake; timer stopped in the ack cycle.
    irq_ack = 1'b1;
    bus_write(A_TCON, 32'h0);
    irq_ack = 1'b0;
    rd_check("ack_icause", A_ICAUSE, 32'h8000_0000);
    check("ack_irq", {31'd0, irq}, 32'd0);
    bus_write(A_IPEND, 32'h1);
    rd_check("ack_w1c", A_IPEND, 32'h0);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    rd_check("eret_icause", A_ICAUSE, 32'h0000_0000);
    tick();
    check("eret_irq", {31'd0, irq}, 32'd0);

    // Priority: timer plus sources 1 and 3.
    kernel = 1'b1;
    bus_write(A_IMASK, 32'hF);
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'h3);
    bus_write(A_TCON, 32'h0);
    src_irq = 3'b101;
    tick(); tick();
    rd_check("prio_pend", A_IPEND, 32'hB);
    check("prio_kernel_irq", {31'd0, irq}, 32'd0);
    kernel = 1'b0;
    handshake(5'd0);
    handshake(5'd1);
    handshake(5'd3);
    rd_check("prio_empty", A_IPEND, 32'h0);

    // Mask and kernel gating, REQ abandoned when kernel rises.
    bus_write(A_IMASK, 32'h0);
    src_irq = 3'b000;
    tick(); tick();
    src_irq = 3'b010;
    tick(); tick();
    rd_check("mask_pend", A_IPEND, 32'h4);
    tick(); tick();
    check("mask_irq", {31'd0, irq}, 32'd0);
    kernel = 1'b1;
    bus_write(A_IMASK, 32'hF);
    tick(); tick();
    check("kernel_irq", {31'd0, irq}, 32'd0);
    kernel = 1'b0;
    tick();
    check("unmask_irq", {31'd0, irq}, 32'd1);
    kernel = 1'b1;
    tick();
    check("req_drop_irq", {31'd0, irq}, 32'd0);
    kernel = 1'b0;
    handshake(5'd2);

    // Set wins over W1C in the same cycle.
    bus_write(A_IMASK, 32'h0);
    src_irq = 3'b000;
    tick(); tick();
    src_irq = 3'b001;
    tick();
    bus_write(A_IPEND, 32'h2);
    rd_check("collide_set", A_IPEND, 32'h2);
    bus_write(A_IPEND, 32'h2);
    rd_check("collide_clr", A_IPEND, 32'h0);

    // Reset while in SVC.
    src_irq = 3'b000;
    tick(); tick();
    bus_write(A_TL, 32'h5);
    bus_write(A_IMASK, 32'hF);
    src_irq = 3'b100;
    wait_irq("svc_irq");
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    rd_check("svc_icause", A_ICAUSE, 32'h8000_0003);
    src_irq = 3'b000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_irq", {31'd0, irq}, 32'd0);
    rd_check("rst_ipend", A_IPEND, 32'h0);
    rd_check("rst_tl", A_TL, 32'h0);
    rd_check("rst_icause2", A_ICAUSE, 32'h0);
    rd_check("rst_imask", A_IMASK, 32'h0);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    rd_check("spur_eret", A_ICAUSE, 32'h0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    rd_check("spur_ack", A_ICAUSE, 32'h0);
    tick();
    check("spur_irq", {31'd0, irq}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
